// File: rtl/uart_tx_feeder.sv
// Byte FIFO feeding a UART transmitter: launches one byte at a time with a
// start pulse and tracks the UART busy handshake, with a timeout on busy rising.
module uart_tx_feeder #(
    parameter int DEPTH        = 8,
    parameter int BUSY_TIMEOUT = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   wr_en,
    input  logic [7:0]             wr_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count,
    output logic                   overflow,
    input  logic                   clr_overflow,
    input  logic                   uart_busy,
    output logic                   start_transmission,
    output logic [7:0]             tx_data,
    output logic                   timeout_err
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int TW = $clog2(BUSY_TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_BUSY,
        WAIT_DONE
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [7:0]      mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [TW-1:0]   busy_timer;
    logic [CW-1:0]   count_next;
    logic            wr_accept;
    logic            wr_drop;
    logic            pop;
    logic            timeout_hit;

    // Full is the registered flag, so a pop in the same cycle never frees room for a write.
    assign wr_accept = wr_en && !full;
    assign wr_drop   = wr_en && full;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = state;
        pop         = 1'b0;
        timeout_hit = 1'b0;
        unique case (state)
            IDLE: begin
                if (!empty && !uart_busy) begin
                    pop        = 1'b1;
                    state_next = WAIT_BUSY;
                end
            end
            WAIT_BUSY: begin
                if (uart_busy) begin
                    state_next = WAIT_DONE;
                end else if (busy_timer == TW'(BUSY_TIMEOUT - 1)) begin
                    timeout_hit = 1'b1;
                    state_next  = IDLE;
                end
            end
            WAIT_DONE: begin
                if (!uart_busy) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        count_next = count;
        if (wr_accept && !pop) begin
            count_next = count + CW'(1);
        end else if (pop && !wr_accept) begin
            count_next = count - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (wr_accept && !reset) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr             <= '0;
            rd_ptr             <= '0;
            count              <= '0;
            full               <= 1'b0;
            empty              <= 1'b1;
            overflow           <= 1'b0;
            timeout_err        <= 1'b0;
            start_transmission <= 1'b0;
            tx_data            <= '0;
            busy_timer         <= '0;
        end else begin
            if (wr_accept) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                tx_data <= mem[rd_ptr];
                rd_ptr  <= rd_ptr + AW'(1);
            end
            start_transmission <= pop;
            count              <= count_next;
            full               <= (count_next == CW'(DEPTH));
            empty              <= (count_next == '0);
            if (wr_drop) begin
                overflow <= 1'b1;
            end else if (clr_overflow) begin
                overflow <= 1'b0;
            end
            if (timeout_hit) begin
                timeout_err <= 1'b1;
            end
            // Timer only runs while waiting for busy; it is already zero on entry to WAIT_BUSY.
            if (state == WAIT_BUSY && !uart_busy) begin
                busy_timer <= busy_timer + TW'(1);
            end else begin
                busy_timer <= '0;
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Scoreboard bench for uart_tx_feeder: queue model of the FIFO, a behavioural
// UART busy responder, and a monitor comparing every cycle and every launch.
module tb_uart_tx_feeder;

    localparam int DEPTH = 8;
    localparam int BT    = 16;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       wr_en = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic       clr_overflow = 1'b0;
    logic       uart_busy = 1'b0;
    logic       full, empty, overflow, start_transmission, timeout_err;
    logic [3:0] count;
    logic [7:0] tx_data;

    uart_tx_feeder #(.DEPTH(DEPTH), .BUSY_TIMEOUT(BT)) dut (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_data(wr_data),
        .full(full), .empty(empty), .count(count), .overflow(overflow),
        .clr_overflow(clr_overflow), .uart_busy(uart_busy),
        .start_transmission(start_transmission), .tx_data(tx_data),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Reference model state
    logic [7:0] exp_q[$];
    int   mcnt = 0;
    bit   movf = 0;
    bit   mto = 0;
    bit   wb = 0;          // launched, busy not yet seen
    bit   wd = 0;          // busy seen, waiting for it to drop
    int   age = 0;
    logic [7:0] last_tx = 8'h00;
    bit   prev_start = 0;
    int   launches = 0;
    // UART responder: 0 = busy for busy_len cycles after each launch, 1 = stuck high, 2 = never busy
    int   busy_mode = 0;
    int   busy_len = 10;
    int   busy_rem = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor + UART responder
    always @(negedge clk) begin
        bit bprev;
        bprev = uart_busy;
        if (reset) begin
            exp_q.delete();
            mcnt = 0; movf = 0; mto = 0; wb = 0; wd = 0; prev_start = 0;
            busy_rem = 0;
            uart_busy = (busy_mode == 1);
            chk("rst_start", int'(start_transmission), 0);
            chk("rst_count", int'(count), 0);
            chk("rst_empty", int'(empty), 1);
            chk("rst_full", int'(full), 0);
            chk("rst_overflow", int'(overflow), 0);
            chk("rst_timeout", int'(timeout_err), 0);
            chk("rst_tx_data", int'(tx_data), 0);
        end else begin
            if (start_transmission) begin
                launches++;
                chk("launch_legal", (wb || wd || prev_start || bprev) ? 1 : 0, 0);
                if (exp_q.size() == 0) begin
                    chk("launch_expected", 1, 0);
                end else begin
                    chk("tx_data", int'(tx_data), int'(exp_q.pop_front()));
                    mcnt--;
                end
                last_tx = tx_data;
            end else if (wb || wd) begin
                chk("tx_stable", int'(tx_data), int'(last_tx));
            end
            if (wb) begin
                if (bprev) begin
                    wb = 0; wd = 1;
                end else begin
                    age++;
                    if (age == BT) begin
                        mto = 1; wb = 0;
                    end
                end
            end else if (wd) begin
                if (!bprev) wd = 0;
            end
            if (start_transmission) begin
                wb = 1; age = 0;
            end
            chk("count", int'(count), mcnt);
            chk("empty", int'(empty), (mcnt == 0) ? 1 : 0);
            chk("full", int'(full), (mcnt == DEPTH) ? 1 : 0);
            chk("overflow", int'(overflow), int'(movf));
            chk("timeout_err", int'(timeout_err), int'(mto));
            prev_start = start_transmission;
            case (busy_mode)
                1: uart_busy = 1'b1;
                2: uart_busy = 1'b0;
                default: begin
                    if (start_transmission) begin
                        uart_busy = 1'b1; busy_rem = busy_len;
                    end else if (busy_rem > 1) begin
                        busy_rem--;
                    end else begin
                        busy_rem = 0; uart_busy = 1'b0;
                    end
                end
            endcase
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic drive(input bit w, input logic [7:0] d, input bit clr);
        bit drop;
        wr_en = w; wr_data = d; clr_overflow = clr;
        if (!reset) begin
            drop = w && (mcnt == DEPTH);
            if (w && !drop) begin
                exp_q.push_back(d);
                mcnt++;
            end
            if (drop) movf = 1;
            else if (clr) movf = 0;
        end
        tick();
        wr_en = 1'b0; clr_overflow = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || wb || wd || uart_busy) && n < 1000) begin
            drive(0, 8'h00, 0);
            n++;
        end
        chk("drain_bound", (n < 1000) ? 1 : 0, 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int l0, n, guard;
        logic [7:0] b;
        #1;
        // Reset, with a write attempted while it is held
        drive(1, 8'hEE, 0);
        repeat (2) drive(0, 8'h00, 0);
        reset = 1'b0;
        drive(0, 8'h00, 0);
        chk("no_write_in_reset", int'(count), 0);

        // Single byte: launch one edge after the write edge
        drive(1, 8'hA5, 0);
        chk("latency_count", int'(count), 1);
        tick();
        chk("latency_start", int'(start_transmission), 1);
        chk("latency_data", int'(tx_data), 8'hA5);
        chk("latency_empty", int'(empty), 1);
        wait_drain();

        // Busy handshake, back-to-back writes (second lands on the pop edge)
        busy_len = 10;
        l0 = launches;
        drive(1, 8'h11, 0);
        drive(1, 8'h22, 0);
        chk("pop_and_write_count", int'(count), 1);
        wait_drain();
        chk("handshake_launches", launches - l0, 2);

        // Overflow with uart held busy
        busy_mode = 1;
        tick();
        l0 = launches;
        for (int i = 0; i < 9; i++) drive(1, 8'h80 + 8'(i), 0);
        chk("ovf_full", int'(full), 1);
        chk("ovf_count", int'(count), 8);
        chk("ovf_flag", int'(overflow), 1);
        drive(1, 8'hF0, 1);
        chk("ovf_drop_beats_clear", int'(overflow), 1);
        drive(0, 8'h00, 1);
        chk("ovf_cleared", int'(overflow), 0);
        busy_mode = 0;
        wait_drain();
        chk("ovf_launches", launches - l0, 8);

        // Timeout: uart never goes busy
        busy_mode = 2;
        tick();
        l0 = launches;
        drive(1, 8'h3C, 0);
        repeat (20) drive(0, 8'h00, 0);
        chk("timeout_set", int'(timeout_err), 1);
        chk("timeout_single_pulse", launches - l0, 1);
        busy_mode = 0;
        drive(1, 8'h5A, 0);
        wait_drain();
        chk("after_timeout_launch", launches - l0, 2);

        // Stream 20 bytes across pointer wrap with short busy
        busy_len = 1;
        l0 = launches;
        n = 0; guard = 0;
        while (n < 20 && guard < 1000) begin
            if ($urandom_range(0, 3) != 0 && mcnt < DEPTH) begin
                drive(1, 8'($urandom), 0);
                n++;
            end else begin
                drive(0, 8'h00, 0);
            end
            guard++;
        end
        wait_drain();
        chk("stream_launches", launches - l0, 20);

        // Random traffic including drops and clears
        for (int i = 0; i < 300; i++) begin
            busy_len = $urandom_range(1, 4);
            b = 8'($urandom);
            drive(($urandom_range(0, 9) < 7) ? 1'b1 : 1'b0, b, ($urandom_range(0, 9) == 0) ? 1'b1 : 1'b0);
        end
        wait_drain();

        // Reset during WAIT_DONE with bytes queued
        busy_len = 10;
        for (int i = 0; i < 4; i++) drive(1, 8'hC0 + 8'(i), 0);
        guard = 0;
        while (!wd && guard < 100) begin
            drive(0, 8'h00, 0);
            guard++;
        end
        chk("reached_wait_done", int'(wd), 1);
        reset = 1'b1;
        drive(1, 8'h77, 0);
        reset = 1'b0;
        chk("midrst_count", int'(count), 0);
        chk("midrst_tx_data", int'(tx_data), 0);
        l0 = launches;
        repeat (40) drive(0, 8'h00, 0);
        chk("midrst_no_launch", launches - l0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
